// File: rtl/ddr_amm_responder.sv
// Avalon-MM DDR responder model: calibration delay, wait-request stalls,
// fixed read latency and bursts over an on-chip word array.
module ddr_amm_responder #(
    parameter int DDR_DATA_WIDTH = 64,
    parameter int DDR_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int INIT_CYCLES    = 16,
    parameter int READ_LATENCY   = 4,
    parameter int WAIT_PERIOD    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DDR_ADDR_WIDTH-1:0] amm_addr,
    input  logic                      amm_ren,
    input  logic                      amm_wen,
    input  logic [DDR_DATA_WIDTH-1:0] amm_wdata,
    input  logic [5:0]                amm_burstcount,
    output logic                      amm_wait,
    output logic                      amm_rvalid,
    output logic [DDR_DATA_WIDTH-1:0] amm_rdata,
    output logic                      local_init_done,
    output logic                      proto_err
);
    localparam int IW    = $clog2(INIT_CYCLES + 1);
    localparam int SW    = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST =
        (WAIT_PERIOD > 0) ? SW'(WAIT_PERIOD - 1) : '0;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                    state;
    logic [IW-1:0]             init_cnt;
    logic [SW-1:0]             stall_cnt;
    logic [MEM_ADDR_WIDTH-1:0] base;
    logic [5:0]                beat_idx;
    logic [5:0]                beat_last;

    logic [DDR_DATA_WIDTH-1:0] mem [DEPTH];
    logic                      issue_v;
    logic [DDR_DATA_WIDTH-1:0] issue_d;
    logic [READ_LATENCY-1:0]   pipe_v;
    logic [DDR_DATA_WIDTH-1:0] pipe_d [READ_LATENCY];

    logic                      present;
    logic                      stall;
    logic                      accept;
    logic [5:0]                eff_bc;
    logic [MEM_ADDR_WIDTH-1:0] cmd_addr;
    logic [MEM_ADDR_WIDTH-1:0] burst_addr;
    logic                      wr_en;
    logic                      rd_en;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr;
    logic                      unused_addr_hi;

    assign present    = amm_ren | amm_wen;
    assign stall      = (WAIT_PERIOD != 0) && present &&
                        (stall_cnt == STALL_LAST);
    assign amm_wait   = ~local_init_done | (state == RD_BURST) | stall;
    assign accept     = present & ~amm_wait;
    assign eff_bc     = (amm_burstcount == 6'd0) ? 6'd1 : amm_burstcount;
    assign cmd_addr   = amm_addr[MEM_ADDR_WIDTH-1:0];
    assign burst_addr = base + MEM_ADDR_WIDTH'(beat_idx);
    assign unused_addr_hi = ^amm_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    assign amm_rvalid = pipe_v[READ_LATENCY-1];
    assign amm_rdata  = amm_rvalid ? pipe_d[READ_LATENCY-1] : '0;

    // Array port selection: command address in IDLE, base+k inside bursts.
    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = cmd_addr;
        rd_addr = cmd_addr;
        case (state)
            IDLE: begin
                wr_en = accept & amm_wen;
                rd_en = accept & amm_ren & ~amm_wen;
            end
            WR_BURST: begin
                wr_en   = accept & amm_wen & ~amm_ren;
                wr_addr = burst_addr;
            end
            RD_BURST: begin
                rd_en   = 1'b1;
                rd_addr = burst_addr;
            end
            default: ;
        endcase
    end

    // Calibration delay: done rises on the INIT_CYCLES-th edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt        <= '0;
            local_init_done <= 1'b0;
        end else if (!local_init_done) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == INIT_LAST)
                local_init_done <= 1'b1;
        end
    end

    // Stall counter: one stall per WAIT_PERIOD presented commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if ((WAIT_PERIOD != 0) && local_init_done &&
                 (state != RD_BURST) && present)
            stall_cnt <= stall ? '0 : stall_cnt + 1'b1;
    end

    // Command FSM: burst tracking and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            beat_idx  <= '0;
            beat_last <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        base      <= cmd_addr;
                        beat_idx  <= 6'd1;
                        beat_last <= eff_bc - 6'd1;
                        if ((amm_burstcount == 6'd0) || (amm_ren && amm_wen))
                            proto_err <= 1'b1;
                        if (eff_bc > 6'd1)
                            state <= amm_wen ? WR_BURST : RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (amm_ren) begin
                        proto_err <= 1'b1;
                    end else if (wr_en) begin
                        beat_idx <= beat_idx + 6'd1;
                        if (beat_idx == beat_last)
                            state <= IDLE;
                    end
                end
                RD_BURST: begin
                    beat_idx <= beat_idx + 6'd1;
                    if (beat_idx == beat_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word array: writes plus synchronous read of the issued beat.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= amm_wdata;
        if (rd_en)
            issue_d <= mem[rd_addr];
    end

    // Read valid pipeline; reset flushes beats in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_v <= 1'b0;
            pipe_v  <= '0;
        end else begin
            issue_v   <= rd_en;
            pipe_v[0] <= issue_v;
            for (int i = 1; i < READ_LATENCY; i++)
                pipe_v[i] <= pipe_v[i-1];
        end
    end

    // Read data pipeline, aligned with the valid pipeline.
    always_ff @(posedge clk) begin
        pipe_d[0] <= issue_d;
        for (int i = 1; i < READ_LATENCY; i++)
            pipe_d[i] <= pipe_d[i-1];
    end
endmodule

// File: tb/tb_ddr_amm_responder.sv
// Self-checking bench for ddr_amm_responder against a queue/array
// reference model of memory contents, stall pattern and read returns.
module tb_ddr_amm_responder;
    localparam int W     = 64;
    localparam int A     = 32;
    localparam int M     = 10;
    localparam int IC    = 16;
    localparam int RL    = 4;
    localparam int WP    = 4;
    localparam int DEPTH = 1 << M;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [A-1:0] amm_addr = '0;
    logic         amm_ren = 1'b0;
    logic         amm_wen = 1'b0;
    logic [W-1:0] amm_wdata = '0;
    logic [5:0]   amm_burstcount = 6'd1;
    logic         amm_wait;
    logic         amm_rvalid;
    logic [W-1:0] amm_rdata;
    logic         local_init_done;
    logic         proto_err;

    ddr_amm_responder #(
        .DDR_DATA_WIDTH(W), .DDR_ADDR_WIDTH(A), .MEM_ADDR_WIDTH(M),
        .INIT_CYCLES(IC), .READ_LATENCY(RL), .WAIT_PERIOD(WP)
    ) dut (
        .clk(clk), .rst(rst), .amm_addr(amm_addr), .amm_ren(amm_ren),
        .amm_wen(amm_wen), .amm_wdata(amm_wdata),
        .amm_burstcount(amm_burstcount), .amm_wait(amm_wait),
        .amm_rvalid(amm_rvalid), .amm_rdata(amm_rdata),
        .local_init_done(local_init_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } beat_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           pres_n = 0;
    logic [W-1:0] ref_mem [DEPTH];
    beat_t        expq [$];
    beat_t        got;

    always @(posedge clk) cyc <= cyc + 1;

    // Return monitor: every rvalid must match the next expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (amm_rvalid === 1'b1) begin
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rvalid: rdata=%h cyc=%0d", amm_rdata, cyc);
                end else begin
                    got = expq.pop_front();
                    if (amm_rdata !== got.data || cyc != got.due) begin
                        bad++;
                        $display("FAIL read_return: data=%h cyc=%0d exp data=%h cyc=%0d",
                                 amm_rdata, cyc, got.data, got.due);
                    end
                end
            end else if (amm_rvalid !== 1'b0 || amm_rdata !== '0) begin
                bad++;
                $display("FAIL idle_rdata: rvalid=%b rdata=%h exp 0/0", amm_rvalid, amm_rdata);
            end
        end
    end

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [A-1:0] rand_addr(input logic [M-1:0] a);
        logic [A-1:0] r;
        r = $urandom();
        r[M-1:0] = a;
        return r;
    endfunction

    task automatic idle_inputs();
        amm_ren = 1'b0;
        amm_wen = 1'b0;
        amm_addr = '0;
        amm_wdata = '0;
        amm_burstcount = 6'd1;
    endtask

    // Present a command at a negedge until accepted; checks wait each cycle.
    task automatic present(input logic r, input logic w, input logic [A-1:0] a,
                           input logic [W-1:0] d, input logic [5:0] bc,
                           output int e);
        int tries;
        logic exp_w;
        tries = 0;
        e = -1;
        amm_ren = r;
        amm_wen = w;
        amm_addr = a;
        amm_wdata = d;
        amm_burstcount = bc;
        forever begin
            #1;
            exp_w = (pres_n % WP) == WP - 1;
            pres_n++;
            total++;
            if (amm_wait !== exp_w) begin
                bad++;
                $display("FAIL wait_pattern: wait=%b exp=%b pres=%0d", amm_wait, exp_w, pres_n);
            end
            if (amm_wait === 1'b0) begin
                e = cyc + 1;
                break;
            end
            tries++;
            if (tries > 8) begin
                bad++;
                $display("FAIL accept_timeout: wait=%b exp=0", amm_wait);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic write_burst(input logic [M-1:0] a, input int n);
        int e;
        logic [W-1:0] d;
        d = rnd64();
        present(1'b0, 1'b1, rand_addr(a), d, 6'(n), e);
        ref_mem[a] = d;
        for (int k = 1; k < n; k++) begin
            d = rnd64();
            present(1'b0, 1'b1, $urandom(), d, 6'($urandom()), e);
            ref_mem[a + M'(k)] = d;
        end
    endtask

    task automatic read_cmd(input logic [M-1:0] a, input int n, input bit chk);
        int e;
        beat_t b;
        present(1'b1, 1'b0, rand_addr(a), '0, 6'(n), e);
        for (int k = 0; k < n; k++) begin
            b.data = ref_mem[a + M'(k)];
            b.due = e + k + RL;
            expq.push_back(b);
        end
        for (int k = 1; k < n; k++) begin
            if (chk) begin
                total++;
                if (amm_wait !== 1'b1) begin
                    bad++;
                    $display("FAIL burst_wait: wait=%b exp=1 beat=%0d", amm_wait, k);
                end
            end
            @(negedge clk);
        end
        if (chk) begin
            total++;
            if (amm_wait !== 1'b0) begin
                bad++;
                $display("FAIL burst_end_wait: wait=%b exp=0", amm_wait);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d exp=0", expq.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        expq.delete();
        pres_n = 0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (amm_wait !== 1'b1 || amm_rvalid !== 1'b0 || amm_rdata !== '0 ||
            local_init_done !== 1'b0 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: wait=%b rv=%b rd=%h done=%b perr=%b exp 1/0/0/0/0",
                     amm_wait, amm_rvalid, amm_rdata, local_init_done, proto_err);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Count edges after release; optionally hold a write the whole time.
    task automatic init_check(input bit hold, input logic [M-1:0] a,
                              input logic [W-1:0] d);
        if (hold) begin
            amm_wen = 1'b1;
            amm_addr = rand_addr(a);
            amm_wdata = d;
        end
        @(negedge clk);
        for (int i = 1; i < IC; i++) begin
            @(negedge clk);
            total++;
            if (amm_wait !== 1'b1 || local_init_done !== 1'b0 || amm_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL init_wait: edge=%0d wait=%b done=%b rv=%b exp 1/0/0",
                         i, amm_wait, local_init_done, amm_rvalid);
            end
        end
        @(negedge clk);
        total++;
        if (local_init_done !== 1'b1) begin
            bad++;
            $display("FAIL init_done: done=%b exp=1", local_init_done);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        init_check(1'b0, '0, '0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH / 32; i++)
            write_burst(M'(i * 32), 32);
    endtask

    task automatic test_single();
        int e;
        present(1'b0, 1'b1, rand_addr(10'd5), 64'h1111_2222_3333_4444, 6'd1, e);
        ref_mem[5] = 64'h1111_2222_3333_4444;
        read_cmd(10'd5, 1, 1'b0);
        drain();
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL single_perr: perr=%b exp=0", proto_err);
        end
    endtask

    task automatic test_init();
        apply_reset();
        init_check(1'b1, 10'd100, ~ref_mem[100]);
        read_cmd(10'd100, 1, 1'b0);
        drain();
    endtask

    task automatic test_stalls();
        int e;
        apply_reset();
        init_check(1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            present(1'b0, 1'b1, rand_addr(M'(i)), W'(i), 6'd1, e);
            ref_mem[i] = W'(i);
        end
        total++;
        if (pres_n != 10) begin
            bad++;
            $display("FAIL stall_count: presented=%0d exp=10", pres_n);
        end
        for (int i = 0; i < 8; i++)
            read_cmd(M'(i), 1, 1'b0);
        drain();
    endtask

    task automatic test_read_burst();
        read_cmd(10'd1020, 8, 1'b1);
        drain();
    endtask

    task automatic test_write_burst_ren();
        int e;
        logic [W-1:0] d;
        drain();
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL pre_burst_perr: perr=%b exp=0", proto_err);
        end
        d = rnd64();
        present(1'b0, 1'b1, rand_addr(10'd10), d, 6'd3, e);
        ref_mem[10] = d;
        d = rnd64();
        present(1'b0, 1'b1, $urandom(), d, 6'd1, e);
        ref_mem[11] = d;
        present(1'b1, 1'b0, rand_addr(10'd40), '0, 6'd1, e);
        d = rnd64();
        present(1'b0, 1'b1, $urandom(), d, 6'd1, e);
        ref_mem[12] = d;
        repeat (8) @(negedge clk);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL ren_in_wr_burst_perr: perr=%b exp=1", proto_err);
        end
        read_cmd(10'd10, 3, 1'b1);
        drain();
    endtask

    task automatic test_proto();
        int e;
        logic [W-1:0] d;
        beat_t b;
        apply_reset();
        init_check(1'b0, '0, '0);
        present(1'b1, 1'b0, rand_addr(10'd300), '0, 6'd0, e);
        b.data = ref_mem[300];
        b.due = e + RL;
        expq.push_back(b);
        drain();
        repeat (4) @(negedge clk);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL zero_burst_perr: perr=%b exp=1", proto_err);
        end
        apply_reset();
        init_check(1'b0, '0, '0);
        d = rnd64();
        present(1'b1, 1'b1, rand_addr(10'd301), d, 6'd1, e);
        ref_mem[301] = d;
        repeat (8) @(negedge clk);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL ren_wen_perr: perr=%b exp=1", proto_err);
        end
        read_cmd(10'd301, 1, 1'b0);
        drain();
    endtask

    task automatic test_random();
        int e;
        logic [M-1:0] a;
        logic [W-1:0] d;
        for (int i = 0; i < 60; i++) begin
            a = M'($urandom());
            case ($urandom_range(0, 3))
                0: begin
                    d = rnd64();
                    present(1'b0, 1'b1, rand_addr(a), d, 6'd1, e);
                    ref_mem[a] = d;
                end
                1: read_cmd(a, 1, 1'b0);
                2: read_cmd(a, $urandom_range(2, 8), 1'b1);
                default: write_burst(a, $urandom_range(2, 8));
            endcase
        end
        drain();
    endtask

    task automatic test_reset_mid();
        read_cmd(10'd700, 3, 1'b0);
        apply_reset();
        init_check(1'b0, '0, '0);
        read_cmd(10'd700, 3, 1'b0);
        read_cmd(10'd5, 1, 1'b0);
        drain();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_single();
        test_init();
        test_stalls();
        test_read_burst();
        test_write_burst_ren();
        test_proto();
        test_random();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
